// File: rtl/mem_port_sched.sv
// Four-requester memory port scheduler: least-recently-granted arbitration,
// whole-transaction grant hold, response return and BUSY timeout abort.
module mem_port_sched #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [3:0]      wr,
  input  logic [4*AW-1:0] addr,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      done,
  output logic [3:0]      err,
  output logic [DW-1:0]   rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : '0;

  state_t      state;
  logic [3:0]  prio [4];  // prio[i][j] set: requester i beats requester j
  logic [15:0] cnt;
  logic [3:0]  eligible;
  logic [3:0]  win;
  logic        timeout;

  assign eligible = req & ~done;
  assign timeout  = TO_EN && (cnt == TO_LAST);

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      win[i] = eligible[i];
      for (int unsigned j = 0; j < 4; j++) begin
        if (j != i && eligible[j] && prio[j][i]) win[i] = 1'b0;
      end
    end
  end

  // gnt is zero outside BUSY, so the port mux idles at zero without a state term.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        mem_addr  = addr[i*AW +: AW];
        mem_wdata = wdata[i*DW +: DW];
      end
    end
  end

  assign mem_req = (state == BUSY);
  assign mem_we  = |(gnt & wr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      err   <= '0;
      rdata <= '0;
      cnt   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned j = 0; j < 4; j++) begin
          prio[i][j] <= (i < j);
        end
      end
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            gnt   <= win;
            state <= BUSY;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (mem_ack || timeout) begin
            done  <= gnt;
            err   <= mem_ack ? 4'b0000 : gnt;
            rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            gnt   <= '0;
            state <= IDLE;
            // Owner drops below everyone; other pairs keep their order.
            for (int unsigned i = 0; i < 4; i++) begin
              for (int unsigned j = 0; j < 4; j++) begin
                if (gnt[i] && i != j) begin
                  prio[i][j] <= 1'b0;
                  prio[j][i] <= 1'b1;
                end
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: directed scenarios plus randomized traffic checked
// against an LRU-ordered-list reference model.
module tb_mem_port_sched;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req, wr;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]      gnt, done, err;
  logic [DW-1:0]   rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  always #5 clk = ~clk;

  mem_port_sched #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transaction owner, age in cycles, and LRU list (front = highest priority)
  bit            m_busy;
  int            m_owner;
  int            m_age;
  logic [3:0]    m_done, m_err;
  logic [DW-1:0] m_rdata;
  int            order [4];
  int            waits [4];
  int            lat;

  task automatic retire(input int o);
    int tmp [4];
    int k;
    k = 0;
    for (int p = 0; p < 4; p++) begin
      if (order[p] != o) begin
        tmp[k] = order[p];
        k++;
      end
    end
    tmp[3] = o;
    order = tmp;
  endtask

  task automatic step();
    bit            n_busy;
    int            n_owner, n_age;
    logic [3:0]    n_done, n_err, elig;
    logic [DW-1:0] n_rdata;
    bit            granted;
    n_busy = m_busy; n_owner = m_owner; n_age = m_age;
    n_done = '0; n_err = '0; n_rdata = m_rdata; granted = 0;
    for (int i = 0; i < 4; i++) if (!req[i]) waits[i] = 0;
    if (rst) begin
      n_busy = 0; n_rdata = '0; n_age = 0;
      order = '{0, 1, 2, 3};
      for (int i = 0; i < 4; i++) waits[i] = 0;
    end else if (!m_busy) begin
      elig = req & ~m_done;
      for (int p = 0; p < 4; p++) begin
        if (!n_busy && elig[order[p]]) begin
          n_busy = 1; n_owner = order[p]; n_age = 0; granted = 1;
        end
      end
    end else if (mem_ack || (TO != 0 && m_age + 1 == TO)) begin
      n_done[m_owner] = 1'b1;
      if (!mem_ack) n_err[m_owner] = 1'b1;
      n_rdata = (mem_ack && !wr[m_owner]) ? mem_rdata : '0;
      n_busy = 0;
      retire(m_owner);
    end else begin
      n_age = m_age + 1;
    end
    if (granted) begin
      for (int i = 0; i < 4; i++) begin
        if (i == n_owner) waits[i] = 0;
        else if (req[i]) begin
          waits[i]++;
          check("fair", waits[i] <= 3, 1);
        end
      end
    end
    @(posedge clk);
    #1;
    m_busy = n_busy; m_owner = n_owner; m_age = n_age;
    m_done = n_done; m_err = n_err; m_rdata = n_rdata;
    check("gnt", gnt, m_busy ? (4'b0001 << m_owner) : 4'b0000);
    check("done", done, m_done);
    check("err", err, m_err);
    if (m_done != 0) check("rdata", rdata, m_rdata);
    check("mem_req", mem_req, m_busy);
    check("mem_we", mem_we, m_busy ? wr[m_owner] : 1'b0);
    if (m_busy) begin
      check("mem_addr", mem_addr, addr[m_owner*AW +: AW]);
      check("mem_wdata", mem_wdata, wdata[m_owner*DW +: DW]);
    end
  endtask

  task automatic set_cmd(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 199) == 0);
    mem_rdata = $urandom;
    if (m_busy) begin
      if (m_age == 0) lat = $urandom_range(0, 5);
      mem_ack = (m_age == lat);
    end else begin
      mem_ack = ($urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 4; i++) begin
      if (m_done[i]) begin
        if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        else set_cmd(i, $urandom_range(0, 1) == 1, $urandom, $urandom);
      end else if (!req[i] && !(m_busy && m_owner == i) && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        set_cmd(i, $urandom_range(0, 1) == 1, $urandom, $urandom);
      end else if (m_busy && m_owner == i && req[i] && $urandom_range(0, 9) == 0) begin
        req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [$];
    int hi;
    rst = 1; req = '0; wr = '0; addr = '0; wdata = '0; mem_ack = 0; mem_rdata = '0;
    m_busy = 0; m_owner = 0; m_age = 0; m_done = '0; m_err = '0; m_rdata = '0;
    order = '{0, 1, 2, 3}; lat = 0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    step(); step();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_done", done, 4'b0000);
    check("rst_rdata", rdata, 0);
    check("rst_mem_req", mem_req, 0);
    rst = 0;

    // all four requesting, immediate acks: 0,1,2,3,0
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      mem_ack = m_busy;
      step();
      for (int i = 0; i < 4; i++) if (gnt[i]) seq.push_back(i);
    end
    check("rr_count", seq.size(), 5);
    for (int k = 0; k < seq.size() && k < 5; k++) check("rr_order", seq[k], k % 4);
    req = '0; mem_ack = 0;
    step();

    // single read with 3-cycle latency
    req = 4'b0100; set_cmd(2, 0, 32'h40, 32'h0);
    step();
    check("rd_gnt", gnt, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      check("rd_addr", mem_addr, 32'h40);
      check("rd_we", mem_we, 0);
      mem_ack = (k == 2);
      mem_rdata = (k == 2) ? 32'hDEADBEEF : 32'h12345678;
      step();
    end
    check("rd_done", done, 4'b0100);
    check("rd_data", rdata, 32'hDEADBEEF);
    mem_ack = 0; req = '0;
    step();
    check("rd_pulse", done, 4'b0000);

    // completed owner masked, newcomer granted
    req = 4'b0001; set_cmd(0, 1, 32'h100, 32'hA5A5A5A5);
    step();
    mem_ack = 1;
    step();
    req = 4'b0011; set_cmd(1, 0, 32'h200, 32'h0); mem_ack = 0;
    step();
    check("mask_gnt", gnt, 4'b0010);
    mem_ack = 1;
    step();
    req = '0; mem_ack = 0;
    step();

    // timeout with no ack, then next requester proceeds
    req = 4'b0010; set_cmd(1, 0, 32'h300, 32'h0);
    step();
    req = 4'b1010; set_cmd(3, 1, 32'h400, 32'h55AA55AA);
    hi = 0;
    for (int k = 0; k < 10 && done == 0; k++) begin
      hi += int'(mem_req);
      step();
    end
    check("to_busy", hi, TO);
    check("to_done", done, 4'b0010);
    check("to_err", err, 4'b0010);
    check("to_rdata", rdata, 0);
    req = 4'b1000;
    step();
    check("to_next", gnt, 4'b1000);
    mem_ack = 1;
    step();
    req = '0; mem_ack = 0;
    step();

    // reset in second BUSY cycle of a write
    req = 4'b0001; set_cmd(0, 1, 32'h500, 32'hCAFEF00D);
    step();
    step();
    check("rw_busy", mem_req, 1);
    rst = 1;
    step();
    check("rw_gnt", gnt, 4'b0000);
    check("rw_mem_req", mem_req, 0);
    check("rw_done", done, 4'b0000);
    rst = 0; req = 4'b1001; set_cmd(3, 0, 32'h600, 32'h0);
    step();
    check("rw_regnt", gnt, 4'b0001);
    mem_ack = 1;
    step();

    // owner drops req mid-transaction
    req = 4'b1000; mem_ack = 0;
    step();
    check("drop_gnt", gnt, 4'b1000);
    req = 4'b0000;
    step();
    mem_ack = 1;
    step();
    check("drop_done", done, 4'b1000);
    mem_ack = 0;
    step();

    for (int c = 0; c < 4000; c++) begin
      drive_random();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Four-requester scheduler sharing one memory/bus port among EXE-stage clients (LSU, fetch refill, CSR/debug, DMA).
- Arbitrates with a least-recently-granted priority matrix and holds the grant for one whole transaction.
- Muxes the owner's command onto the port, returns the response to the owner, and aborts stalled transactions on a timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, maximum BUSY cycles without mem_ack before abort; 0 disables the timeout; legal range 0..65535.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  per-requester request level; held with its command until done is seen.
- wr  in  4  per-requester write enable (1 = write).
- addr  in  4*AW  per-requester address; requester i uses bits [i*AW +: AW].
- wdata  in  4*DW  per-requester write data; requester i uses bits [i*DW +: DW].
- gnt  out  4  registered one-hot owner; 0 when idle.
- done  out  4  one-cycle completion pulse to the owner.
- err  out  4  one-cycle timeout pulse to the owner; coincides with done.
- rdata  out  DW  registered read data; valid while done is high.
- mem_req  out  1  port request; high for the whole BUSY state.
- mem_we  out  1  write enable driven from the owner.
- mem_addr  out  AW  address driven from the owner.
- mem_wdata  out  DW  write data driven from the owner.
- mem_ack  in  1  port completion; sampled only in BUSY.
- mem_rdata  in  DW  read data; valid with mem_ack.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; gnt, done, err = 0; rdata = 0; timeout counter = 0.
  - Priority matrix reset order: 0 > 1 > 2 > 3.
  - Reset mid-transaction abandons it; mem_req is low from the next cycle; no done or err pulse.
- State IDLE:
  - eligible = req & ~done. The owner just completed is masked for one cycle.
  - If eligible != 0: winner = eligible requester with no higher-priority eligible requester in the matrix.
  - On the winning edge: gnt <= one-hot winner, state <= BUSY, counter <= 0.
- State BUSY:
  - mem_req=1; mem_we, mem_addr and mem_wdata are combinationally muxed from the gnt requester.
  - Outside BUSY: mem_req=0 and mem_we=0; mem_addr and mem_wdata are don't-care.
  - Requester inputs may change while BUSY; the port follows the live owner inputs, which the owner must hold stable.
  - Dropping req while BUSY does not cancel the transaction.
- Completion (mem_ack=1 in BUSY):
  - Next edge: done <= gnt, rdata <= mem_rdata (0 for writes), gnt <= 0, state <= IDLE.
  - The matrix makes the owner lowest priority, with the relative order of the others unchanged.
- Timeout (TIMEOUT != 0, counter reaches TIMEOUT-1 with no ack):
  - Next edge: done <= gnt, err <= gnt, rdata <= 0, gnt <= 0, state <= IDLE.
  - Priority updates exactly as on completion.
- Timing:
  - done and err are single-cycle pulses.
  - Minimum transaction: grant edge N, mem_req high in cycle N, ack in cycle N, done in cycle N+1.
  - Next grant at edge N+2, so at most one transaction every 2 cycles.
- Ack, timeout and reset together: mem_ack wins over timeout in the same cycle; rst wins over everything.
- Invariants: gnt is one-hot or zero; at most one done bit is set; mem_ack outside BUSY is ignored.
- Fairness: a continuously requesting client is granted within 3 other transactions.

Test Plan:
- Reset, then req=4'b1111 with 1-cycle acks -> grants 0,1,2,3,0 in order; each done one cycle after its ack; gnt idle 1 cycle between grants.
- req=4'b0100 only, wr[2]=0, addr2=0x40, ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x40 and mem_we=0 for 3 cycles; done=4'b0100 and rdata=0xDEADBEEF for exactly 1 cycle.
- Requester 0 holds req after done, requester 1 requests the same cycle -> requester 1 is granted next (mask plus priority).
- TIMEOUT=4, req=4'b0010, never ack -> mem_req high exactly 4 cycles; then done=err=4'b0010 for 1 cycle, rdata=0, and the next requester proceeds.
- rst=1 in the second BUSY cycle of a write -> next cycle gnt=0 and mem_req=0, no done; after reset, req=4'b1000|4'b0001 grants requester 0.
- Requester 3 drops req mid-BUSY, ack arrives -> done[3] still pulses; the transaction is not cancelled.
